pipe_stage_buf: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers. One generic stage with a ready/valid handshake and a 2-entry skid buffer, so backpressure never drops or duplicates an instruction.
- Payload has two parts. The data part is held on a bubble. The control part (jump, stop, write-enable-type bits) is forced to a safe value on a bubble or flush.
- Instantiated between any two pipeline stages (RR->EX, EX->MEM, ...).

---
 rtl/pipe_stage_buf.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf: ready/valid pipeline stage with a 2-entry skid buffer.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buf #(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter bit                NEGEDGE  = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_ready_q, in_ready_d;
  logic                in_fire;
  logic                out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q & resetn;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    in_ready_d  = in_ready_q;
    if (!resetn) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = CTRL_RST;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_RST;
      in_ready_d  = 1'b1;
    end else if (flush) begin
      // Data stays put; only the control side is made safe.
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_RST;
      skid_ctrl_d = CTRL_RST;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            in_ready_d  = 1'b0;
          end else if (out_fire) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_RST;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = CTRL_RST;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = CTRL_RST;
          skid_ctrl_d = CTRL_RST;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!resetn) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // Same register set, clocked on whichever edge the instance selects.
  generate
    if (NEGEDGE) begin : g_negedge
      always_ff @(negedge clk) begin
        state_q     <= state_d;
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        in_ready_q  <= in_ready_d;
`ifdef PIPE_STALL_CNT_EN
        stall_q     <= stall_d;
`endif
      end
    end else begin : g_posedge
      always_ff @(posedge clk) begin
        state_q     <= state_d;
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        in_ready_q  <= in_ready_d;
`ifdef PIPE_STALL_CNT_EN
        stall_q     <= stall_d;
`endif
      end
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

endmodule

`default_nettype wire
